// File: rtl/pport_responder.sv
`default_nettype none
// ============================================================================
// Module   : pport_responder
// Purpose  : VM1 bus target with DATA/STATUS registers, output byte FIFO,
//            input byte latch and FIFO-empty interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module pport_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'o177714,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_bus,
  input  logic [15:0] bus_addr,
  input  logic        bus_sync,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_ack,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_strobe,
  output logic        irq
);

  localparam int         AW = $clog2(FIFO_DEPTH);
  localparam int         CW = AW + 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  wcnt, wcnt_nx;
  logic        sel, start, effect;

  logic        lat_we, lat_reg, lat_wtbt0;
  logic [7:0]  lat_din;
  logic        e_we, e_reg, e_wtbt0;
  logic [7:0]  e_din;

  logic        push_req, push, pop, flush, set_irq_en, rd_data, rd_status;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        full, empty;

  logic        ovf, irq_en, in_full;
  logic [7:0]  in_latch;
  logic [6:0]  cnt7;
  logic [15:0] status_word, rdata;
  logic        unused_bits;

  assign unused_bits = ^{bus_din[15:8], bus_wtbt[1], bus_addr[0]};

  assign sel = bus_sync & (bus_addr[15:2] == BASE_ADDR[15:2]);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= 3'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    start    = 1'b0;
    effect   = 1'b0;
    if (ce_bus) begin
      case (state)
        S_IDLE: begin
          if (sel & bus_stb) begin
            start = 1'b1;
            if (WAIT_STATES == 0) begin
              state_nx = S_ACK;
              effect   = 1'b1;
            end else begin
              state_nx = S_WAIT;
              wcnt_nx  = WS;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 3'd0) begin
            state_nx = S_ACK;
            effect   = 1'b1;
          end else begin
            wcnt_nx = wcnt - 3'd1;
          end
        end
        S_ACK: begin
          if (!bus_stb) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_reg   <= 1'b0;
      lat_wtbt0 <= 1'b0;
      lat_din   <= 8'h00;
    end else if (start) begin
      lat_we    <= bus_we;
      lat_reg   <= bus_addr[1];
      lat_wtbt0 <= bus_wtbt[0];
      lat_din   <= bus_din[7:0];
    end
  end

  // Zero-wait-state cycles execute on the detect tick, before the latch loads.
  always_comb begin
    if (state == S_IDLE) begin
      e_we    = bus_we;
      e_reg   = bus_addr[1];
      e_wtbt0 = bus_wtbt[0];
      e_din   = bus_din[7:0];
    end else begin
      e_we    = lat_we;
      e_reg   = lat_reg;
      e_wtbt0 = lat_wtbt0;
      e_din   = lat_din;
    end
  end

  assign push_req   = effect & e_we & ~e_reg & e_wtbt0;
  assign set_irq_en = effect & e_we & e_reg & e_wtbt0;
  assign flush      = set_irq_en & e_din[0];
  assign rd_data    = effect & ~e_we & ~e_reg;
  assign rd_status  = effect & ~e_we & e_reg;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & out_ready;
  assign push  = push_req & (~full | pop) & ~flush;

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop)      count <= count + CW'(1);
      else if (pop & ~push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= e_din;
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ovf      <= 1'b0;
      irq_en   <= 1'b0;
      in_full  <= 1'b0;
      in_latch <= 8'h00;
      irq      <= 1'b0;
    end else begin
      if (push_req & full & ~pop) ovf <= 1'b1;
      else if (rd_status)         ovf <= 1'b0;
      if (set_irq_en) irq_en <= e_din[6];
      // A fresh input byte outranks the clear from a concurrent DATA read.
      if (in_strobe) begin
        in_latch <= in_data;
        in_full  <= 1'b1;
      end else if (rd_data) begin
        in_full <= 1'b0;
      end
      irq <= irq_en & empty;
    end
  end

  always_comb begin
    cnt7 = '0;
    cnt7[CW-1:0] = count;
    status_word = {ovf, cnt7, empty, irq_en, full, in_full, 4'b0000};
  end

  // Read word is captured at ACK entry so the clear-on-read cannot alter it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rdata <= 16'h0000;
    end else if (effect & ~e_we) begin
      rdata <= e_reg ? status_word : {8'h00, in_latch};
    end
  end

  assign bus_ack  = (state == S_ACK);
  assign bus_dout = (state == S_ACK && !lat_we) ? rdata : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_pport_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pport_responder
// Purpose  : Randomised scoreboard bench for pport_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pport_responder;

  localparam int          DEPTH = 16;
  localparam int          WS    = 1;
  localparam logic [15:0] BASE  = 16'o177714;

  logic        clk_sys   = 1'b0;
  logic        reset     = 1'b1;
  logic        ce_bus    = 1'b0;
  logic [15:0] bus_addr  = 16'h0000;
  logic        bus_sync  = 1'b0;
  logic        bus_stb   = 1'b0;
  logic        bus_we    = 1'b0;
  logic [1:0]  bus_wtbt  = 2'b00;
  logic [15:0] bus_din   = 16'h0000;
  logic [15:0] bus_dout;
  logic        bus_ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data   = 8'h00;
  logic        in_strobe = 1'b0;
  logic        irq;

  pport_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_bus   (ce_bus),
    .bus_addr (bus_addr),
    .bus_sync (bus_sync),
    .bus_stb  (bus_stb),
    .bus_we   (bus_we),
    .bus_wtbt (bus_wtbt),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .bus_ack  (bus_ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data  (in_data),
    .in_strobe(in_strobe),
    .irq      (irq)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model: register file plus a byte queue for the FIFO.
  logic [7:0]  mq[$];
  logic [15:0] exp_rd[$];
  bit          m_ovf = 0, m_irq_en = 0, m_in_full = 0;
  logic [7:0]  m_in_latch = 8'h00;
  bit          cur_we = 0, ce_rand = 1, prev_ack = 0, prev_cond = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] status_word();
    logic [15:0] w;
    w       = 16'h0000;
    w[15]   = m_ovf;
    w[14:8] = 7'(mq.size());
    w[7]    = (mq.size() == 0);
    w[6]    = m_irq_en;
    w[5]    = (mq.size() == DEPTH);
    w[4]    = m_in_full;
    return w;
  endfunction

  task automatic model_apply(input bit we, input bit rs, input logic [1:0] wtbt, input logic [15:0] din);
    if (we && !rs && wtbt[0]) begin
      if (mq.size() >= DEPTH) m_ovf = 1;
      else mq.push_back(din[7:0]);
    end else if (we && rs && wtbt[0]) begin
      m_irq_en = din[6];
      if (din[0]) mq.delete();
    end else if (!we && !rs) begin
      m_in_full = 0;
    end else if (!we && rs) begin
      m_ovf = 0;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rd.delete();
    m_ovf = 0; m_irq_en = 0; m_in_full = 0; m_in_latch = 8'h00;
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      ce_bus = ce_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: compares every presented output against the model and queues.
  initial begin
    bit cond;
    forever begin
      @(negedge clk_sys);
      #2;
      if (reset) begin
        prev_cond = 0;
        prev_ack  = 0;
        continue;
      end
      chk("irq", 32'(irq), 32'(prev_cond));
      cond = m_irq_en && (mq.size() == 0);
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (out_valid && out_ready) begin
        if (mq.size() == 0) fail_now("unexpected_pop");
        else chk("stream_byte", 32'(out_data), 32'(mq.pop_front()));
      end
      if (bus_ack && !prev_ack && !cur_we) begin
        if (exp_rd.size() == 0) fail_now("unexpected_read_ack");
        else chk("read_word", 32'(bus_dout), 32'(exp_rd.pop_front()));
      end else if (!bus_ack || cur_we) begin
        chk("dout_zero", 32'(bus_dout), 32'h0);
      end
      prev_cond = cond;
      prev_ack  = bus_ack;
    end
  end

  task automatic bus_xfer(input bit we, input bit rs, input logic [1:0] wtbt, input logic [15:0] din,
                          input bit strobe_at_entry, input logic [7:0] sdata);
    int ticks = 0;
    int guard = 0;
    bit got   = 0;
    if (!we) exp_rd.push_back(rs ? status_word() : {8'h00, m_in_latch});
    @(negedge clk_sys);
    cur_we   = we;
    bus_addr = BASE + (rs ? 16'd2 : 16'd0);
    bus_we   = we;
    bus_wtbt = wtbt;
    bus_din  = din;
    bus_sync = 1'b1;
    bus_stb  = 1'b1;
    while (!got && guard < 200) begin
      @(posedge clk_sys);
      guard++;
      if (ce_bus) ticks++;
      #1;
      if (bus_ack) got = 1;
      else if (strobe_at_entry && ticks == WS + 1) begin
        in_data   = sdata;
        in_strobe = 1'b1;
      end
    end
    in_strobe = 1'b0;
    if (!got) begin
      fail_now("ack_timeout");
      if (!we) void'(exp_rd.pop_back());
    end else begin
      chk("ack_latency", 32'(ticks), 32'((WS == 0) ? 1 : WS + 2));
      model_apply(we, rs, wtbt, din);
      if (strobe_at_entry) begin
        m_in_latch = sdata;
        m_in_full  = 1;
      end
    end
    @(negedge clk_sys);
    bus_stb = 1'b0;
    guard = 0;
    while (bus_ack && guard < 200) begin
      @(posedge clk_sys);
      #1;
      guard++;
    end
    if (bus_ack) fail_now("ack_release_timeout");
    @(negedge clk_sys);
    bus_sync = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] b);
    bus_xfer(1, 0, 2'b11, {8'h00, b}, 0, 8'h00);
  endtask

  task automatic rd_reg(input bit rs);
    bus_xfer(0, rs, 2'b11, 16'h0000, 0, 8'h00);
  endtask

  task automatic pulse_in(input logic [7:0] d);
    @(negedge clk_sys);
    in_data   = d;
    in_strobe = 1'b1;
    @(posedge clk_sys);
    #1;
    m_in_latch = d;
    m_in_full  = 1;
    @(negedge clk_sys);
    in_strobe = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int g = 0;
    while (mq.size() != 0 && g < 400) begin
      @(negedge clk_sys);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      g++;
    end
    out_ready = 1'b0;
    if (mq.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    #1;
    chk("reset_ack", 32'(bus_ack), 32'h0);
    chk("reset_dout", 32'(bus_dout), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rd_reg(1);

    // Three word writes, status, then stream them out.
    wr_data(8'h41);
    wr_data(8'h42);
    wr_data(8'h43);
    rd_reg(1);
    drain(0);
    @(negedge clk_sys);
    #2;
    chk("empty_after_drain", 32'(out_valid), 32'h0);

    // Overflow: 17 writes into a 16-deep FIFO.
    repeat (17) wr_data(8'($urandom_range(0, 255)));
    rd_reg(1);
    rd_reg(1);
    bus_xfer(1, 1, 2'b01, 16'h0001, 0, 8'h00);

    // High-byte-only write does not push.
    bus_xfer(1, 0, 2'b10, 16'h0099, 0, 8'h00);
    rd_reg(1);

    // Input latch, clear-on-read, and strobe colliding with the read.
    pulse_in(8'h5A);
    rd_reg(1);
    rd_reg(0);
    rd_reg(1);
    ce_rand = 0;
    repeat (2) @(negedge clk_sys);
    bus_xfer(0, 0, 2'b11, 16'h0000, 1, 8'hA5);
    rd_reg(1);
    rd_reg(0);
    ce_rand = 1;

    // Flush with irq enable, then push/drain toggles irq.
    repeat (5) wr_data(8'($urandom_range(0, 255)));
    bus_xfer(1, 1, 2'b01, 16'h0041, 0, 8'h00);
    #2;
    chk("irq_after_flush", 32'(irq), 32'h1);
    rd_reg(1);
    wr_data(8'h33);
    #2;
    chk("irq_after_push", 32'(irq), 32'h0);
    drain(0);
    repeat (2) @(negedge clk_sys);
    #2;
    chk("irq_after_drain", 32'(irq), 32'h1);
    bus_xfer(1, 1, 2'b01, 16'h0000, 0, 8'h00);

    // Reset while a DATA write sits in WAIT.
    ce_rand = 0;
    repeat (2) @(negedge clk_sys);
    @(negedge clk_sys);
    cur_we   = 1;
    bus_addr = BASE;
    bus_we   = 1'b1;
    bus_wtbt = 2'b01;
    bus_din  = 16'h0077;
    bus_sync = 1'b1;
    bus_stb  = 1'b1;
    @(posedge clk_sys);
    #1;
    reset    = 1'b1;
    bus_stb  = 1'b0;
    bus_sync = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk_sys);
      #1;
      chk("ack_after_reset", 32'(bus_ack), 32'h0);
    end
    wr_data(8'h66);
    rd_reg(1);
    drain(0);
    ce_rand = 1;

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus_xfer(1, 0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)), 0, 8'h00);
        4:          rd_reg(1);
        5, 9:       rd_reg(0);
        6:          pulse_in(8'($urandom_range(0, 255)));
        7:          drain(1);
        default: begin
          d = 16'h0000;
          d[6] = 1'($urandom_range(0, 1));
          d[0] = ($urandom_range(0, 3) == 0);
          bus_xfer(1, 1, 2'($urandom_range(0, 3)), d, 0, 8'h00);
        end
      endcase
    end
    drain(1);
    repeat (3) @(negedge clk_sys);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
